// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential reads to a registered-output memory
// and queues {pc, word} pairs in a small FIFO for the decoder.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 12,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 12'h000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc_r;
  logic [ADDR_WIDTH-1:0] req_pc_r;
  logic                  pending_r;
  logic [ADDR_WIDTH-1:0] fifo_pc_r   [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  valid_r;
  logic [DATA_WIDTH-1:0] head_data_r;
  logic [ADDR_WIDTH-1:0] head_pc_r;

  logic                  pop_s;
  logic                  push_s;
  logic                  issue_s;
  logic [CNT_W:0]        occupancy_s;
  logic [PTR_W-1:0]      wr_ptr_nxt_s;
  logic [PTR_W-1:0]      rd_ptr_nxt_s;
  logic [CNT_W-1:0]      count_nxt_s;
  logic [DATA_WIDTH-1:0] head_data_nxt_s;
  logic [ADDR_WIDTH-1:0] head_pc_nxt_s;

  assign mem_addr         = fetch_pc_r;
  assign mem_write_enable = 1'b0;
  assign instr_valid      = valid_r;
  assign instr_data       = head_data_r;
  assign instr_pc         = head_pc_r;

  // Credit check counts the in-flight read so a push can never hit a full FIFO.
  assign pop_s       = valid_r & instr_ready;
  assign push_s      = pending_r & ~redirect_valid;
  assign occupancy_s = (CNT_W+1)'(count_r) + (CNT_W+1)'(pending_r) - (CNT_W+1)'(pop_s);
  assign issue_s     = ~halt & ~redirect_valid & (occupancy_s < (CNT_W+1)'(DEPTH));

  // Next FIFO pointers and occupancy; redirect empties the queue.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (redirect_valid) begin
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      count_nxt_s  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1'b1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
        2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Next head value; the word being pushed bypasses storage when it becomes the head.
  always_comb begin
    head_pc_nxt_s   = fifo_pc_r[rd_ptr_nxt_s];
    head_data_nxt_s = fifo_data_r[rd_ptr_nxt_s];
    if (count_nxt_s == {CNT_W{1'b0}}) begin
      head_pc_nxt_s   = {ADDR_WIDTH{1'b0}};
      head_data_nxt_s = {DATA_WIDTH{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_pc_nxt_s   = req_pc_r;
      head_data_nxt_s = mem_data_out;
    end else begin
      head_pc_nxt_s   = fifo_pc_r[rd_ptr_nxt_s];
      head_data_nxt_s = fifo_data_r[rd_ptr_nxt_s];
    end
  end

  // PC, request tracking, FIFO control and registered head outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r  <= RESET_PC;
      req_pc_r    <= {ADDR_WIDTH{1'b0}};
      pending_r   <= 1'b0;
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      valid_r     <= 1'b0;
      head_data_r <= {DATA_WIDTH{1'b0}};
      head_pc_r   <= {ADDR_WIDTH{1'b0}};
    end else begin
      if (redirect_valid) begin
        fetch_pc_r <= redirect_addr;
      end else if (issue_s) begin
        fetch_pc_r <= fetch_pc_r + ADDR_WIDTH'(1'b1);
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      if (issue_s) begin
        req_pc_r <= fetch_pc_r;
      end else begin
        req_pc_r <= req_pc_r;
      end
      pending_r   <= issue_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      valid_r     <= (count_nxt_s != {CNT_W{1'b0}});
      head_data_r <= head_data_nxt_s;
      head_pc_r   <= head_pc_nxt_s;
    end
  end

  // FIFO storage, written at the tail on each push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_r[i]   <= {ADDR_WIDTH{1'b0}};
        fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      fifo_pc_r[wr_ptr_r]   <= req_pc_r;
      fifo_data_r[wr_ptr_r] <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a registered memory model returns addr ^ 0xA5A and a
// scoreboard queue of expected PCs is checked against every accepted instruction.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [11:0] mem_addr;
  logic        mem_write_enable;
  logic [11:0] mem_data_out;
  logic        halt;
  logic        redirect_valid;
  logic [11:0] redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] instr_data;
  logic [11:0] instr_pc;

  int          total;
  int          bad;
  int          n_acc;
  logic [11:0] last_exp;
  logic [11:0] sb [$];

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_data_out     (mem_data_out),
    .halt             (halt),
    .redirect_valid   (redirect_valid),
    .redirect_addr    (redirect_addr),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_data       (instr_data),
    .instr_pc         (instr_pc)
  );

  always #5 clk = ~clk;

  // Memory with one cycle of read latency.
  always @(posedge clk) mem_data_out <= mem_addr ^ 12'hA5A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refill(input logic [11:0] start);
    logic [11:0] p;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      p = start + 12'(i);
      sb.push_back(p);
    end
  endtask

  // Check any handshake completing at the coming posedge, then move to just after the next negedge.
  task automatic tick();
    logic [11:0] e;
    if (!rst && !redirect_valid && instr_valid && instr_ready) begin
      n_acc++;
      e = sb.pop_front();
      last_exp = e;
      chk("acc_pc", 32'(instr_pc), 32'(e));
      chk("acc_data", 32'(instr_data), 32'(e ^ 12'hA5A));
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 12'h000;
    instr_ready = 1'b1;
    total = 0;
    bad = 0;
    n_acc = 0;
    last_exp = 12'h000;
    #1;
    tick();
    tick();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_data", 32'(instr_data), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_we", 32'(mem_write_enable), 32'd0);

    // Streaming from reset: valid rises in the second cycle, then no gaps.
    refill(12'h000);
    rst = 1'b0;
    chk("lat0", 32'(instr_valid), 32'd0);
    tick();
    chk("lat1", 32'(instr_valid), 32'd0);
    tick();
    chk("lat2", 32'(instr_valid), 32'd1);
    chk("lat2_pc", 32'(instr_pc), 32'h000);
    for (int i = 0; i < 6; i++) begin
      chk("nogap", 32'(instr_valid), 32'd1);
      tick();
    end

    // Backpressure from reset: two entries buffered, address frozen.
    rst = 1'b1;
    tick();
    instr_ready = 1'b0;
    refill(12'h000);
    rst = 1'b0;
    repeat (6) tick();
    chk("bp_addr", 32'(mem_addr), 32'h002);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_pc", 32'(instr_pc), 32'h000);
    chk("bp_data", 32'(instr_data), 32'hA5A);
    instr_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_drain_valid", 32'(instr_valid), 32'd1);
      tick();
    end
    chk("bp_drain_cnt", 32'(n_acc), 32'd3);
    repeat (3) tick();

    // Redirect mid-stream with ready high in the same cycle.
    redirect_valid = 1'b1;
    redirect_addr = 12'h100;
    refill(12'h100);
    tick();
    redirect_valid = 1'b0;
    chk("rd_v1", 32'(instr_valid), 32'd0);
    tick();
    chk("rd_v2", 32'(instr_valid), 32'd0);
    tick();
    chk("rd_v3", 32'(instr_valid), 32'd1);
    chk("rd_pc", 32'(instr_pc), 32'h100);
    chk("rd_data", 32'(instr_data), 32'hB5A);
    repeat (4) tick();

    // Address wrap.
    redirect_valid = 1'b1;
    redirect_addr = 12'hFFE;
    refill(12'hFFE);
    n_acc = 0;
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    chk("wrap_cnt", 32'(n_acc), 32'd6);

    // Halt: the head and the in-flight word drain, then nothing.
    halt = 1'b1;
    n_acc = 0;
    repeat (5) tick();
    chk("halt_cnt", 32'(n_acc), 32'd2);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_addr", 32'(mem_addr), 32'(last_exp + 12'h001));
    halt = 1'b0;
    repeat (6) tick();
    chk("resume_valid", 32'(instr_valid), 32'd1);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(instr_valid), 32'd0);
    chk("ar_data", 32'(instr_data), 32'd0);
    chk("ar_pc", 32'(instr_pc), 32'd0);
    chk("ar_addr", 32'(mem_addr), 32'd0);
    tick();
    refill(12'h000);
    rst = 1'b0;
    tick();
    tick();
    chk("ar_restart_valid", 32'(instr_valid), 32'd1);
    chk("ar_restart_pc", 32'(instr_pc), 32'h000);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
